// File: rtl/ic_74148_seq.sv
// ic_74148_seq: registered N-to-W priority encoder, valid/ready grant.
// Optional mask input is enabled by defining IC_74148_SEQ_MASK_EN.
module ic_74148_seq #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
`ifdef IC_74148_SEQ_MASK_EN
  input  logic [N-1:0]  mask_i,
`endif
  input  logic          ready_i,
  output logic          valid_o,
  output logic [W-1:0]  code_o,
  output logic          gs_o,
  output logic [N-1:0]  pending_o,
  output logic [DW-1:0] drops_o
);

  if ((1 << W) != N) begin : g_bad_width
    $error("ic_74148_seq: 2**W must equal N");
  end

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  localparam logic [31:0] DMAX = 32'((64'd1 << DW) - 64'd1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [W-1:0]  code_q, code_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          gs_q, gs_d;
  logic [DW-1:0] drops_q, drops_d;

  logic [N-1:0]  msk;
  logic          acc;
  logic [N-1:0]  clr;
  logic [N-1:0]  elig;
  logic [31:0]   dcnt;
  logic [31:0]   dsum;

`ifdef IC_74148_SEQ_MASK_EN
  assign msk = mask_i;
`else
  assign msk = '0;
`endif

  // highest set index wins; lower hits are overwritten by higher ones
  function automatic logic [W-1:0] prio(input logic [N-1:0] v);
    prio = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) prio = W'(i);
    end
  endfunction

  assign valid_o   = (state_q == HOLD);
  assign acc       = valid_o & ready_i;
  assign clr       = acc ? (ONE << code_q) : '0;
  assign elig      = pend_q & ~clr & ~msk;
  assign code_o    = code_q;
  assign gs_o      = gs_q;
  assign pending_o = pend_q;
  assign drops_o   = drops_q;

  // pending set/clear (set wins) and saturating merge counter
  always_comb begin
    pend_d = (pend_q & ~clr) | req_i;
    gs_d   = |(pend_d & ~msk);
    dcnt   = '0;
    for (int i = 0; i < N; i++) begin
      dcnt = dcnt + 32'(req_i[i] & pend_q[i] & ~clr[i]);
    end
    dsum    = 32'(drops_q) + dcnt;
    drops_d = (dsum > DMAX) ? DMAX[DW-1:0] : dsum[DW-1:0];
  end

  // grant FSM: launch from IDLE, chain back-to-back grants on accept
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (en_i && (elig != '0)) begin
          state_d = HOLD;
          code_d  = prio(elig);
        end
      end
      HOLD: begin
        if (acc) begin
          if (en_i && (elig != '0)) begin
            code_d = prio(elig);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      gs_q    <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      gs_q    <= gs_d;
      drops_q <= drops_d;
    end
  end

endmodule

// File: tb/tb_ic_74148_seq.sv
// tb_ic_74148_seq: directed and random checks of ic_74148_seq
// against a cycle-level behavioural model.
module tb_ic_74148_seq;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         ready = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] mask = '0;

  logic         valid, valid2;
  logic [W-1:0] code, code2;
  logic         gs, gs2;
  logic [N-1:0] pending, pending2;
  logic [7:0]   drops;
  logic [1:0]   drops2;

  int n_tot = 0;
  int n_bad = 0;

  bit         m_valid;
  int         m_code;
  bit [N-1:0] m_pend;
  bit         m_gs;
  int         m_drops;
  int         m_drops2;

  always #5 clk = ~clk;

  ic_74148_seq #(.N(N), .W(W), .DW(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .req_i     (req),
`ifdef IC_74148_SEQ_MASK_EN
    .mask_i    (mask),
`endif
    .ready_i   (ready),
    .valid_o   (valid),
    .code_o    (code),
    .gs_o      (gs),
    .pending_o (pending),
    .drops_o   (drops)
  );

  ic_74148_seq #(.N(N), .W(W), .DW(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .req_i     (req),
`ifdef IC_74148_SEQ_MASK_EN
    .mask_i    (mask),
`endif
    .ready_i   (ready),
    .valid_o   (valid2),
    .code_o    (code2),
    .gs_o      (gs2),
    .pending_o (pending2),
    .drops_o   (drops2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_bit(input bit [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_valid  = 0;
    m_code   = 0;
    m_pend   = '0;
    m_gs     = 0;
    m_drops  = 0;
    m_drops2 = 0;
  endtask

  // one clock of the model, from the inputs presented to this edge
  task automatic m_step();
    bit [N-1:0] clr;
    bit [N-1:0] avail;
    int merged;
    clr = '0;
    if (m_valid && ready) clr[m_code] = 1'b1;
    merged   = $countones(req & m_pend & ~clr);
    m_drops  = (m_drops + merged > 255) ? 255 : m_drops + merged;
    m_drops2 = (m_drops2 + merged > 3) ? 3 : m_drops2 + merged;
    avail = m_pend & ~clr & ~mask;
    if (!m_valid || ready) begin
      if (en && avail != 0) begin
        m_valid = 1;
        m_code  = top_bit(avail);
      end else begin
        m_valid = 0;
      end
    end
    m_pend = (m_pend & ~clr) | req;
    m_gs   = ((m_pend & ~mask) != 0);
  endtask

  task automatic cmp_all();
    check("valid", 32'(valid), 32'(m_valid));
    check("code", 32'(code), 32'(m_code));
    check("pend", 32'(pending), 32'(m_pend));
    check("gs", 32'(gs), 32'(m_gs));
    check("drops", 32'(drops), 32'(m_drops));
    check("drops2", 32'(drops2), 32'(m_drops2));
  endtask

  task automatic cyc(input logic [N-1:0] r,
                     input logic e,
                     input logic rd);
    req   = r;
    en    = e;
    ready = rd;
    m_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  int exp_codes[4] = '{7, 5, 2, 0};
  int d0;

  initial begin
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_gs", 32'(gs), 32'd0);
    check("rst_drops", 32'(drops), 32'd0);
    rst = 1'b0;

    // reset asserted in the middle of a HOLD cycle
    cyc(8'h90, 1, 0);
    cyc(8'h90, 1, 0);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_code", 32'(code), 32'd7);
    check("t1_pend", 32'(pending), 32'h90);
    check("t1_drops", 32'(drops), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check("t1r_valid", 32'(valid), 32'd0);
    check("t1r_pend", 32'(pending), 32'd0);
    check("t1r_drops", 32'(drops), 32'd0);
    check("t1r_code", 32'(code), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single request, consumer stalls then accepts
    cyc(8'h08, 1, 0);
    check("t2_v1", 32'(valid), 32'd0);
    cyc(8'h00, 1, 0);
    check("t2_v2", 32'(valid), 32'd1);
    check("t2_code", 32'(code), 32'd3);
    cyc(8'h00, 1, 0);
    cyc(8'h00, 1, 0);
    check("t2_hold", 32'(code), 32'd3);
    cyc(8'h00, 1, 1);
    check("t2_done", 32'(valid), 32'd0);
    check("t2_pend", 32'(pending), 32'd0);

    // multi-hot burst drained back to back
    cyc(8'hA5, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 1, 1);
      check("t3_valid", 32'(valid), 32'd1);
      check("t3_code", 32'(code), 32'(exp_codes[i]));
    end
    cyc(8'h00, 1, 1);
    check("t3_end", 32'(valid), 32'd0);
    check("t3_gs", 32'(gs), 32'd0);

    // same-cycle set and clear of the granted bit
    cyc(8'h10, 1, 0);
    cyc(8'h00, 1, 0);
    check("t4_code", 32'(code), 32'd4);
    d0 = int'(drops);
    cyc(8'h10, 1, 1);
    check("t4_pend", 32'(pending[4]), 32'd1);
    check("t4_drops", 32'(drops), 32'(d0));
    cyc(8'h00, 1, 0);
    check("t4_regrant", 32'(valid), 32'd1);
    check("t4_code2", 32'(code), 32'd4);
    cyc(8'h00, 1, 1);

    // repeated request while disabled counts merges
    d0 = int'(drops);
    for (int i = 0; i < 5; i++) cyc(8'h01, 0, 0);
    check("t5_pend", 32'(pending), 32'h01);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_drops", 32'(drops), 32'(d0 + 4));
    check("t5_sat", 32'(drops2), 32'd3);
    cyc(8'h00, 1, 1);
    check("t5_code", 32'(code), 32'd0);
    cyc(8'h00, 1, 1);

    // accumulate while disabled, then enable
    cyc(8'h42, 0, 0);
    cyc(8'h00, 0, 0);
    check("t6_pend", 32'(pending), 32'h42);
    check("t6_novalid", 32'(valid), 32'd0);
`ifdef IC_74148_SEQ_MASK_EN
    mask = 8'h40;
    cyc(8'h00, 1, 0);
    check("t6_c1", 32'(code), 32'd1);
    cyc(8'h00, 1, 1);
    check("t6_idle", 32'(valid), 32'd0);
    check("t6_left", 32'(pending), 32'h40);
    check("t6_gs", 32'(gs), 32'd0);
    mask = 8'h00;
    cyc(8'h00, 1, 0);
    check("t6_c6", 32'(code), 32'd6);
    cyc(8'h00, 1, 1);
`else
    cyc(8'h00, 1, 0);
    check("t6_c6", 32'(code), 32'd6);
    cyc(8'h00, 1, 1);
    check("t6_c1", 32'(code), 32'd1);
    cyc(8'h00, 1, 1);
    check("t6_idle", 32'(valid), 32'd0);
`endif

    // all requests pending at once
    cyc(8'hFF, 1, 1);
    for (int i = N - 1; i >= 0; i--) begin
      cyc(8'h00, 1, 1);
      check("all_code", 32'(code), 32'(i));
    end
    cyc(8'h00, 1, 1);
    check("all_end", 32'(valid), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
`ifdef IC_74148_SEQ_MASK_EN
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
`endif
      cyc(($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
          ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
